rr_mux_arbiter: RTL
===================

// Module: rr_mux_arbiter
// PURPOSE
// - 4-requester round-robin arbiter that sequences a 4:1 data mux onto one shared output channel.
// - Each requester presents a valid/data pair; the block picks one winner, drives the mux select and
//   forwards the winner's word through a one-entry registered output stage with a valid/ready handshake.
// - Sits between four producers and a single downstream consumer; out_sel mirrors the 4:1 mux select.
// PARAMETERS
// - DW  default 8  data width per requester and of out_data
// PORTS
// - clk        in   1     rising-edge clock, the only clock
// - rst_n      in   1     synchronous, active-low reset (sampled on clk rising edge)
// - in_valid   in   4     per-requester valid; once high it must stay high until accepted
// - in_data    in   4*DW  requester n occupies bits [n*DW +: DW]
// - in_ready   out  4     one-hot accept strobe to the granted requester
// - out_valid  out  1     output register holds a word
// - out_ready  in   1     downstream accepts when out_valid && out_ready
// - out_data   out  DW    registered forwarded word
// - out_sel    out  2     current grant index (mux select: bit1 = upper stage, bit0 = lower stage)
// - busy       out  1     high in BUSY state
// BEHAVIOUR
// - Reset (rst_n=0 at clk edge): state=IDLE, ptr=0, grant=0, out_valid=0, out_data=0; in_ready=0 while in reset.
// - The reset takes effect mid-transfer too: a pending out word is dropped and the handshake is not completed.
// - State IDLE:
//   - If |in_valid: winner = first set bit scanning ptr, ptr+1, ... mod 4.
//   - grant<=winner, state->BUSY. Arbitration latency is 1 cycle.
//   - If in_valid==0: stay in IDLE.
// - State BUSY:
//   - in_ready[g] = (state==BUSY) && (!out_valid || out_ready); all other in_ready bits are 0 (combinational).
//   - Accept (in_valid[g] && in_ready[g]): out_data<=in_data[g], out_valid<=1, ptr<=(g+1) mod 4 (wraps 3->0), state->IDLE.
//   - Abandon (in_valid[g]==0 while BUSY, protocol violation): state->IDLE, ptr unchanged, no load.
// - Output register:
//   - Load has priority over drain.
//   - If out_valid && out_ready && no load in that cycle: out_valid<=0, out_data holds its last value.
//   - Load and drain in the same cycle is a legal back-to-back case with no bubble on the output side.
// - Throughput: at most 1 word per 2 cycles (arbitrate + transfer).
// - out_sel == grant at all times; it changes only when IDLE selects a winner.
// - Fairness: a continuously requesting requester waits at most 3 other grants.
// - The mux is built as three 2:1 stages: s[0] selects within pairs {0,1} and {2,3}, s[1] selects between the pairs.
// CONFIGURATION
// - Macro ARB_LOCK_EN, defined: adds ports in_last (in, 4) and out_last (out, 1).
//   - BUSY holds grant across beats; each accept loads out_data and out_last<=in_last[g].
//   - State->IDLE and ptr<=g+1 only on the accept whose in_last[g]=1; packets are never interleaved.
//   - Between beats, BUSY stays in BUSY while in_valid[g]=0 (no abandon rule).
//   - out_last resets to 0.
// - Macro ARB_LOCK_EN, undefined: in_last and out_last do not exist; every grant is a single beat as above.
// TESTING
// - Reset: hold rst_n=0 for 3 clk with in_valid=4'hF -> out_valid=0, in_ready=0, out_sel=0; first grant after release goes to requester 0.
// - Single request: in_valid=4'b0100, data2=8'hA5, out_ready=1 -> out_sel=2 at cycle 1, in_ready=4'b0100 at cycle 1, out_data=8'hA5 with out_valid=1 at cycle 2.
// - Rotation: in_valid=4'hF held, out_ready=1 -> grant order 0,1,2,3,0 over 10 cycles; ptr wraps 3->0.
// - Back-pressure: out_ready=0 with out_valid=1 -> in_ready stays 0, out_data is stable; raising out_ready -> the next word loads in the same cycle as the drain.
// - Abandon: grant=1, then in_valid[1] drops before accept -> IDLE next cycle, ptr unchanged, no out_valid pulse.
// - ARB_LOCK_EN: req0 sends 3 beats (last on the 3rd) while req1 is valid -> beats 0,0,0 out with out_last on the 3rd, then req1 is granted.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
// 4-requester round-robin arbiter driving a 4:1 data mux into a one-entry valid/ready output register.
// Optional macro ARB_LOCK_EN: grant is held across beats until in_last, adding in_last/out_last ports.
//
// state | meaning
// IDLE  | no grant active; picks the next winner when any in_valid is set
// BUSY  | grant held; winner's word is accepted when the output stage can take it
module rr_mux_arbiter #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      in_valid,
  input  logic [4*DW-1:0] in_data,
  output logic [3:0]      in_ready,
`ifdef ARB_LOCK_EN
  input  logic [3:0]      in_last,
  output logic            out_last,
`endif
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  output logic [1:0]      out_sel,
  output logic            busy
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    grant_q, grant_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
`ifdef ARB_LOCK_EN
  logic          out_last_q, out_last_d;
`endif

  logic [1:0]    winner;
  logic          found;
  logic          ready_ok;
  logic          accept;
  logic [DW-1:0] mux_lo, mux_hi, mux_out;

  // Scan starts at ptr so the most recently served requester is checked last.
  always_comb begin
    winner = ptr_q;
    found  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!found && in_valid[ptr_q + 2'(i)]) begin
        winner = ptr_q + 2'(i);
        found  = 1'b1;
      end
    end
  end

  // Three 2:1 stages: grant bit0 picks within each pair, bit1 picks the pair.
  assign mux_lo  = grant_q[0] ? in_data[1*DW +: DW] : in_data[0*DW +: DW];
  assign mux_hi  = grant_q[0] ? in_data[3*DW +: DW] : in_data[2*DW +: DW];
  assign mux_out = grant_q[1] ? mux_hi : mux_lo;

  assign ready_ok = rst_n && (state_q == BUSY) && (!out_valid_q || out_ready);
  assign in_ready = ready_ok ? (4'b0001 << grant_q) : 4'b0000;
  assign accept   = ready_ok && in_valid[grant_q];

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
`ifdef ARB_LOCK_EN
    out_last_d  = out_last_q;
`endif

    case (state_q)
      IDLE: begin
        if (|in_valid) begin
          grant_d = winner;
          state_d = BUSY;
        end
      end
      BUSY: begin
`ifdef ARB_LOCK_EN
        if (accept && in_last[grant_q]) begin
          ptr_d   = grant_q + 2'd1;
          state_d = IDLE;
        end
`else
        if (accept) begin
          ptr_d   = grant_q + 2'd1;
          state_d = IDLE;
        end else if (!in_valid[grant_q]) begin
          state_d = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    // A load wins over a drain, so both together keep out_valid high with no bubble.
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_out;
`ifdef ARB_LOCK_EN
      out_last_d  = in_last[grant_q];
`endif
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      grant_q     <= 2'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef ARB_LOCK_EN
      out_last_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
`ifdef ARB_LOCK_EN
      out_last_q  <= out_last_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = grant_q;
  assign busy      = (state_q == BUSY);
`ifdef ARB_LOCK_EN
  assign out_last  = out_last_q;
`endif

endmodule
